// File: rtl/aes_encrypt_seq.sv
// aes_encrypt_seq -- iterative AES (FIPS-197) encryption core.
//
// Accepts one 128-bit block and an Nk-word key when start is seen in IDLE.
// It expands the whole key schedule into an internal store (one word per
// cycle) and then runs one cipher round per cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          encrypt request, honoured only in IDLE
//   data_in        plaintext, data_in[127:120] is byte 0
//   key_in         cipher key, key_in[Nk*32-1 -: 32] is word w[0]
//   busy           high in KEXP, ROUND and DONE
//   done           one-cycle pulse when data_encrypted is updated
//   data_encrypted ciphertext, held until the next DONE or reset
//   state_dbg      current FSM state (IDLE=0, KEXP=1, ROUND=2, DONE=3)
//
// Handshake: start is a level request sampled on every rising edge while
// the FSM is in IDLE; the edge that samples it high is the accept edge,
// after which start, data_in and key_in are don't-care until done.
module aes_encrypt_seq #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     data_in,
  input  logic [Nk*32-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic [127:0]     data_encrypted,
  output logic [1:0]       state_dbg
);

  localparam int NW     = 4 * (Nr + 1);
  localparam int WIDX_W = $clog2(NW);
  localparam int RW     = $clog2(Nr + 1);
  localparam int KW     = 3;

  // Stored with entry 255 as the first table value, so lookup index is ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t              state_q;
  logic [127:0]        blk_q;
  logic [WIDX_W-1:0]   widx_q;   // index i of the word being expanded
  logic [KW-1:0]       kmod_q;   // i mod Nk, tracked without a divider
  logic [7:0]          rcon_q;
  logic [RW-1:0]       rnd_q;
  logic [31:0]         w_q [NW];

  logic [31:0]         w_prev, w_back, w_rot, w_sub, w_tmp, w_new;
  logic [WIDX_W-1:0]   rk_base;
  logic [127:0]        round_key, round_out;
  logic [7:0]          sb [16];
  logic [7:0]          sr [16];
  logic [7:0]          mc [16];
  logic                last_round;

  assign state_dbg = state_q;

  // Key expansion datapath: the four S-boxes here are the only ones KEXP uses.
  always_comb begin
    w_prev = w_q[widx_q - WIDX_W'(1)];
    w_back = w_q[widx_q - WIDX_W'(Nk)];
    w_rot  = (kmod_q == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    if (kmod_q == '0)
      w_tmp = w_sub ^ {rcon_q, 24'h0};
    else if (Nk > 6 && kmod_q == KW'(4))
      w_tmp = w_sub;
    else
      w_tmp = w_prev;
    w_new = w_back ^ w_tmp;
  end

  assign rk_base    = WIDX_W'({rnd_q, 2'b00});
  assign round_key  = {w_q[rk_base], w_q[rk_base + WIDX_W'(1)],
                       w_q[rk_base + WIDX_W'(2)], w_q[rk_base + WIDX_W'(3)]};
  assign last_round = (rnd_q == RW'(Nr));

  // One full round; byte k of the block sits in row k%4, column k/4.
  always_comb begin
    sb        = '{default: '0};
    sr        = '{default: '0};
    mc        = '{default: '0};
    round_out = '0;
    for (int i = 0; i < 16; i++)
      sb[i] = sbox(blk_q[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      round_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end

  // Schedule store carries no reset: every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int j = 0; j < Nk; j++)
        w_q[j] <= key_in[Nk*32-1-32*j -: 32];
    end else if (state_q == KEXP) begin
      w_q[widx_q] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      blk_q          <= '0;
      widx_q         <= '0;
      kmod_q         <= '0;
      rcon_q         <= '0;
      rnd_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      data_encrypted <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            blk_q   <= data_in ^ key_in[Nk*32-1 -: 128];
            widx_q  <= WIDX_W'(Nk);
            kmod_q  <= '0;
            rcon_q  <= 8'h01;
            busy    <= 1'b1;
            state_q <= KEXP;
          end
        end
        KEXP: begin
          kmod_q <= (kmod_q == KW'(Nk - 1)) ? '0 : kmod_q + KW'(1);
          if (kmod_q == '0)
            rcon_q <= xtime(rcon_q);
          if (widx_q == WIDX_W'(NW - 1)) begin
            rnd_q   <= RW'(1);
            state_q <= ROUND;
          end else begin
            widx_q <= widx_q + WIDX_W'(1);
          end
        end
        ROUND: begin
          blk_q <= round_out;
          if (last_round) begin
            data_encrypted <= round_out;
            done           <= 1'b1;
            state_q        <= DONE;
          end else begin
            rnd_q <= rnd_q + RW'(1);
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_seq.sv
// tb_aes_encrypt_seq -- bench for aes_encrypt_seq with Nk = 4, 6 and 8.
//
// Each key size gets its own DUT, driver and monitor. The driver pushes the
// expected ciphertext and the expected done cycle into queues at the accept
// edge; the monitor pops and compares whenever done is seen. Expected
// ciphertexts come from a reference model built from the FIPS-197 rules,
// with its S-box derived from GF(2^8) inversion plus the affine map.
module tb_aes_encrypt_seq;

  localparam logic [255:0] KEY_SEQ =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_SEQ = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_ready = 1'b0;
  int inst_done = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] sb_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb_m[v[31:24]], sb_m[v[23:16]], sb_m[v[15:8]], sb_m[v[7:0]]};
  endfunction

  function automatic logic [127:0] aes_model(input int nk, input logic [255:0] key,
                                             input logic [127:0] pt);
    int nr;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  col [4];
    logic [7:0]  coef [4];
    logic [127:0] res;
    nr = nk + 6;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int p = 1; p < i / nk; p++) rc = gmul(rc, 8'h02);
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k < 16; k++)
      s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sb_m[s[k]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          t[4*c + rw] = s[4*((c + rw) % 4) + rw];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) col[j] = t[4*c + j];
          for (int rw = 0; rw < 4; rw++) begin
            t[4*c + rw] = 8'h00;
            for (int j = 0; j < 4; j++)
              t[4*c + rw] = t[4*c + rw] ^ gmul(coef[(j - rw + 4) % 4], col[j]);
          end
        end
      end
      for (int k = 0; k < 16; k++)
        s[k] = t[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- per-key-size DUT, driver, monitor ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int NK  = 4 + 2*gi;
    localparam int NR  = NK + 6;
    localparam int LAT = 4*(NR+1) - NK + NR;
    localparam logic [127:0] KAT = (NK == 4) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                                   (NK == 6) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                               128'h8ea2b7ca516745bfeafc49904b496089;

    logic             rst_n, start, busy, done;
    logic [127:0]     data_in, data_encrypted;
    logic [NK*32-1:0] key_in;
    logic [1:0]       state_dbg;

    logic [127:0] exp_q[$];
    int           exp_t_q[$];

    aes_encrypt_seq #(.Nk(NK)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .data_in        (data_in),
      .key_in         (key_in),
      .busy           (busy),
      .done           (done),
      .data_encrypted (data_encrypted),
      .state_dbg      (state_dbg)
    );

    // Monitor / scoreboard
    always @(negedge clk) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL nk%0d_unexpected_done: got done=1 at cycle %0d, expected no pulse",
                   NK, cyc);
        end else begin
          check($sformatf("nk%0d_result", NK), data_encrypted, exp_q.pop_front());
          check($sformatf("nk%0d_done_cycle", NK), 128'(cyc), 128'(exp_t_q.pop_front()));
        end
      end
    end

    task automatic wait_until(input int t);
      while (cyc < t) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Raises start for exactly the accept edge, then scrambles the inputs.
    task automatic issue(input logic [127:0] d, input logic [255:0] k,
                         input logic [127:0] e, output int a);
      data_in = d;
      key_in  = k[255 -: NK*32];
      start   = 1'b1;
      @(posedge clk);
      #1;
      a = cyc;
      start = 1'b0;
      exp_q.push_back(e);
      exp_t_q.push_back(a + LAT);
      data_in = rand128();
      key_in  = NK*32'({rand128(), rand128()});
      check($sformatf("nk%0d_busy_after_accept", NK), 128'(busy), 128'(1));
    endtask

    task automatic run_one(input logic [127:0] d, input logic [255:0] k,
                           input logic [127:0] e);
      int a;
      issue(d, k, e, a);
      wait_until(a + LAT + 1);
      check($sformatf("nk%0d_idle_busy", NK), 128'(busy), 128'(0));
      check($sformatf("nk%0d_idle_state", NK), 128'(state_dbg), 128'(0));
    endtask

    initial begin : drive
      logic [255:0] k, k2;
      logic [127:0] d, d2;
      int a;
      rst_n = 1'b0; start = 1'b0; data_in = '0; key_in = '0;
      wait (model_ready);
      #2;
      check($sformatf("nk%0d_reset_busy", NK), 128'(busy), 128'(0));
      check($sformatf("nk%0d_reset_done", NK), 128'(done), 128'(0));
      check($sformatf("nk%0d_reset_data", NK), data_encrypted, 128'(0));
      check($sformatf("nk%0d_reset_state", NK), 128'(state_dbg), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Known-answer vector, accepted on the first edge after reset release
      run_one(PT_SEQ, KEY_SEQ, KAT);

      // FIPS-197 appendix example key (extended with random words when Nk > 4)
      k = {128'h2b7e151628aed2a6abf7158809cf4f3c, rand128()};
      d = 128'h3243f6a8885a308d313198a2e0370734;
      run_one(d, k, (NK == 4) ? 128'h3925841d02dc09fbdc118597196a0b32 : aes_model(NK, k, d));

      // Random blocks and keys with random idle gaps
      for (int n = 0; n < 4; n++) begin
        k = {rand128(), rand128()};
        d = rand128();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        run_one(d, k, aes_model(NK, k, d));
      end

      // Back-to-back with start held: second accept K+Nr+2 edges later
      k = {rand128(), rand128()};  d = rand128();
      k2 = {rand128(), rand128()}; d2 = rand128();
      data_in = d; key_in = k[255 -: NK*32]; start = 1'b1;
      @(posedge clk);
      #1;
      a = cyc;
      exp_q.push_back(aes_model(NK, k, d));
      exp_t_q.push_back(a + LAT);
      data_in = d2; key_in = k2[255 -: NK*32];
      exp_q.push_back(aes_model(NK, k2, d2));
      exp_t_q.push_back(a + 2*LAT + 2);
      wait_until(a + LAT + 2);
      start = 1'b0;
      wait_until(a + 2*LAT + 3);
      check($sformatf("nk%0d_b2b_idle_busy", NK), 128'(busy), 128'(0));

      // start pulsed during ROUND with different data is ignored
      k = {rand128(), rand128()}; d = rand128();
      issue(d, k, aes_model(NK, k, d), a);
      wait_until(a + LAT - NR + 3);
      data_in = rand128(); start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check($sformatf("nk%0d_busy_ignored_start", NK), 128'(busy), 128'(1));
      wait_until(a + LAT + 1);
      check($sformatf("nk%0d_ignore_idle_busy", NK), 128'(busy), 128'(0));

      // Reset 20 cycles into a run aborts it at once, with no done pulse
      k = {rand128(), rand128()}; d = rand128();
      issue(d, k, aes_model(NK, k, d), a);
      wait_until(a + 20);
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      void'(exp_t_q.pop_back());
      check($sformatf("nk%0d_abort_busy", NK), 128'(busy), 128'(0));
      check($sformatf("nk%0d_abort_done", NK), 128'(done), 128'(0));
      check($sformatf("nk%0d_abort_data", NK), data_encrypted, 128'(0));
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run_one(PT_SEQ, KEY_SEQ, KAT);

      repeat (3) @(posedge clk);
      #1;
      check($sformatf("nk%0d_pending_results", NK), 128'(exp_q.size()), 128'(0));
      inst_done++;
    end
  end

  // ---------------- S-box build, watchdog, final report ----------------
  initial begin : top
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8];
      sb_m[x] = s ^ 8'h63;
    end
    model_ready = 1'b1;
    for (int t = 0; t < 20000 && inst_done < 3; t++) @(posedge clk);
    if (inst_done < 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got %0d drivers finished, expected 3", inst_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_seq.md
AES_ENCRYPT_SEQ -- requirements
Module: aes_encrypt_seq

Interface
REQ-001 Parameter Nk, default 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 Parameter Nr, default Nk+6, number of cipher rounds.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to encrypt; sampled on rising clk edges.
REQ-006 data_in  input  128  plaintext block; data_in[127:120] is byte 0 (FIPS-197 order).
REQ-007 key_in  input  Nk*32  cipher key; key_in[Nk*32-1 -: 32] is word w[0].
REQ-008 busy  output  1  high while an operation is in progress (KEXP, ROUND or DONE).
REQ-009 done  output  1  one-cycle pulse when data_encrypted becomes valid.
REQ-010 data_encrypted  output  128  ciphertext block, same byte order as data_in.

Function
REQ-011 The block SHALL implement the FIPS-197 AES cipher, inverting the team's Decryption block for identical Nk, key and block.
REQ-012 The FSM SHALL have exactly four states: IDLE, KEXP, ROUND and DONE.
REQ-013 In IDLE with start=1, the next edge SHALL capture key_in and set state register = data_in XOR key_in[Nk*32-1 -: 128], then enter KEXP; this is the accept edge.
REQ-014 start SHALL be ignored in every state except IDLE; data_in and key_in need only be stable on the accept edge.
REQ-015 KEXP SHALL generate one expanded key word per cycle, w[Nk] through w[4*(Nr+1)-1], into an internal schedule store: K = 4*(Nr+1)-Nk cycles (40/46/52 for Nk=4/6/8).
REQ-016 The expansion SHALL apply RotWord+SubWord+Rcon when i mod Nk = 0, and SubWord only when Nk=8 and i mod Nk = 4.
REQ-017 Rcon SHALL start at 0x01 and advance by xtime in GF(2^8) with polynomial 0x11B, reaching 0x1B then 0x36.
REQ-018 ROUND SHALL execute one round per cycle for round r = 1..Nr: SubBytes, ShiftRows, MixColumns (omitted when r = Nr), then AddRoundKey with w[4r..4r+3].
REQ-019 After round Nr the FSM SHALL enter DONE, load data_encrypted with the state, and assert done for exactly that one cycle.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-021 Latency: done SHALL be high in the cycle following K+Nr edges after the accept edge (50 cycles for Nk=4, 58 for Nk=6, 66 for Nk=8).
REQ-022 With start held high, back-to-back operations SHALL be accepted every K+Nr+2 cycles.
REQ-023 data_encrypted SHALL hold its value from the DONE cycle until the next DONE cycle or reset, including while a later operation runs.
REQ-024 busy SHALL be 0 only in IDLE.
REQ-025 The S-box SHALL be combinational within the block; 4 S-box lookups SHALL be shared by KEXP, and 16 SHALL be used by ROUND.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, data_encrypted=0, and clear all counters and Rcon, independent of clk.
REQ-027 Reset asserted during KEXP or ROUND SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After reset release, the first edge with start=1 SHALL be a valid accept edge.

Verification
REQ-029 Nk=4, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> done after 50 cycles, data_encrypted = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> data_encrypted = 3925841d02dc09fbdc118597196a0b32.
REQ-031 Nk=6, key 000102...1617, data 00112233445566778899aabbccddeeff -> done after 58 cycles, data_encrypted = dda97ca4864cdfe06eaf70a0ec0d7191.
REQ-032 Nk=8, key 000102...1e1f, same data -> done after 66 cycles, data_encrypted = 8ea2b7ca516745bfeafc49904b496089.
REQ-033 Pulse start during ROUND with a different data_in -> it is ignored, the original result is produced, and busy stays 1.
REQ-034 Assert rst_n=0 at cycle 20 of an Nk=4 run -> busy=0, done=0 and data_encrypted=0 immediately, with no done pulse; a fresh REQ-029 run then passes.
REQ-035 Loopback: feed data_encrypted and the key into the team's Decryption block -> the original plaintext is recovered for all Nk.
